// File: rtl/xmem_loader_pkg.sv
// ---------------------------------------------------------------------------
// xmem_loader_pkg
// Shared definitions for the external-memory loader: default widths and the
// loader FSM state encoding.
// ---------------------------------------------------------------------------
package xmem_loader_pkg;

    // Default memory address width; the loader's length field is one bit
    // wider so a full-memory load (2^MEM_ADDR_W words) can be expressed.
    localparam int XMEM_ADDR_W   = 10;
    localparam int XMEM_LEN_W    = XMEM_ADDR_W + 1;
    localparam int XMEM_DATA_W   = 32;

    typedef enum logic [1:0] {
        LDR_IDLE   = 2'd0,
        LDR_STREAM = 2'd1,
        LDR_FLUSH  = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/xmem_loader_agen.sv
// ---------------------------------------------------------------------------
// xmem_loader_agen
// Address/length bookkeeping for the loader. Latches stride and length on a
// load pulse, keeps the strided write address and the accepted-word count,
// and flags the word that completes the transfer.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   i_load       latch configuration, restart address and count
//   i_step       one word accepted: advance address and count
//   i_start      first write address
//   i_incr       address stride
//   i_len        number of words in the transfer
//   o_cur_addr   address for the word being accepted now
//   o_last       the word accepted now is the final one
// ---------------------------------------------------------------------------
module xmem_loader_agen #(
    parameter int MEM_ADDR_W = 10,
    parameter int LEN_W      = MEM_ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [MEM_ADDR_W-1:0] i_start,
    input  logic [MEM_ADDR_W-1:0] i_incr,
    input  logic [LEN_W-1:0]      i_len,
    output logic [MEM_ADDR_W-1:0] o_cur_addr,
    output logic                  o_last
);

    logic [MEM_ADDR_W-1:0] r_addr;
    logic [MEM_ADDR_W-1:0] r_incr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;

    // The address adder is MEM_ADDR_W wide on purpose: strides wrap around
    // the memory silently. The counter is LEN_W wide so it can reach
    // 2^MEM_ADDR_W after a full load without overflowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_incr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_start;
            r_incr <= i_incr;
            r_len  <= i_len;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + r_incr;
            r_cnt  <= r_cnt + LEN_W'(1);
        end
    end

    assign o_cur_addr = r_addr;
    assign o_last     = (r_cnt == (r_len - LEN_W'(1)));

endmodule

// File: rtl/xmem_loader.sv
// ---------------------------------------------------------------------------
// xmem_loader
// Drains a valid/ready word stream into a Versat memory's host write port at
// addresses start, start+incr, start+2*incr, ... and exposes the usual
// run/done pair so the controller treats it like any functional unit.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   run        start pulse, honoured only while idle with len != 0
//   done       high while idle
//   start      first write address (latched on run)
//   incr       address stride (latched on run)
//   len        number of words (latched on run)
//   in_valid   stream word available
//   in_data    stream word
//   in_ready   loader accepts a word this cycle
//   mem_valid  memory host valid
//   mem_we     memory host write enable (always equal to mem_valid)
//   mem_addr   memory host address
//   mem_wdata  memory host write data
// ---------------------------------------------------------------------------
module xmem_loader
    import xmem_loader_pkg::*;
#(
    parameter int MEM_ADDR_W = XMEM_ADDR_W,
    parameter int DATA_W     = XMEM_DATA_W,
    parameter int LEN_W      = MEM_ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  done,
    input  logic [MEM_ADDR_W-1:0] start,
    input  logic [MEM_ADDR_W-1:0] incr,
    input  logic [LEN_W-1:0]      len,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata
);

    ldr_state_t            r_state;
    ldr_state_t            w_next;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_last;
    logic [MEM_ADDR_W-1:0] w_cur_addr;
    logic                  r_mem_valid;
    logic [MEM_ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;

    // A zero-length run would never produce a last word, so it is dropped
    // here and the loader simply stays idle.
    assign w_load = (r_state == LDR_IDLE) && run && (len != '0);

    // in_ready comes only from the state register, so the handshake never
    // feeds back combinationally into the upstream valid.
    assign w_hs = in_valid && (r_state == LDR_STREAM);

    xmem_loader_agen #(
        .MEM_ADDR_W (MEM_ADDR_W),
        .LEN_W      (LEN_W)
    ) u_agen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_hs),
        .i_start    (start),
        .i_incr     (incr),
        .i_len      (len),
        .o_cur_addr (w_cur_addr),
        .o_last     (w_last)
    );

    // State register; reset drops straight to idle so done/in_ready react
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LDR_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FLUSH is the single cycle in which the final write sits on the host
    // port; done is only raised once that write has been taken.
    always_comb begin
        w_next   = r_state;
        done     = 1'b0;
        in_ready = 1'b0;
        case (r_state)
            LDR_IDLE: begin
                done = 1'b1;
                if (w_load) begin
                    w_next = LDR_STREAM;
                end
            end
            LDR_STREAM: begin
                in_ready = 1'b1;
                if (w_hs && w_last) begin
                    w_next = LDR_FLUSH;
                end
            end
            LDR_FLUSH: begin
                w_next = LDR_IDLE;
            end
            default: begin
                w_next = LDR_IDLE;
                done   = 1'b1;
            end
        endcase
    end

    // Host-port registers: valid pulses one cycle after each handshake,
    // address/data hold their last values between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_valid <= w_hs;
            if (w_hs) begin
                r_mem_addr  <= w_cur_addr;
                r_mem_wdata <= in_data;
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_xmem_loader.sv
// ---------------------------------------------------------------------------
// tb_xmem_loader
// Drives randomized and directed transfers into xmem_loader. Expected writes
// (address, data, cycle) are pushed into a queue when a word is offered; a
// monitor pops and compares every host-port write.
// ---------------------------------------------------------------------------
module tb_xmem_loader;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          run      = 1'b0;
    logic          done;
    logic [AW-1:0] start    = '0;
    logic [AW-1:0] incr     = '0;
    logic [LW-1:0] len      = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    xmem_loader #(
        .MEM_ADDR_W (AW),
        .DATA_W     (DW),
        .LEN_W      (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .done      (done),
        .start     (start),
        .incr      (incr),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Cycle counter read at negedges to time each write against its offer
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            when;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   writeCount[DEPTH];

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every host write must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checkOutput("mem_we equals mem_valid", 64'(mem_we), 64'(mem_valid));
            if (mem_valid === 1'b1) begin
                writeCount[mem_addr]++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected write", 64'(1), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write addr", 64'(mem_addr), 64'(e.addr));
                    checkOutput("write data", 64'(mem_wdata), 64'(e.data));
                    checkOutput("write cycle", 64'(cyc), 64'(e.when));
                end
            end
        end
    end

    // One transfer. mode: 0 = in_valid always 1, 1 = random, 2 = pattern.
    // abortAfter != 0 pulls reset between edges after that many words.
    // midRun re-issues run with a different start while streaming.
    task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] inc,
                                 input int l, input int mode, input logic [6:0] pat,
                                 input int abortAfter, input bit midRun);
        int   sent  = 0;
        int   k     = 0;
        int   guard = 0;
        int   addrInt;
        bit   v;
        exp_t e;

        @(negedge clk);
        start = s;
        incr  = inc;
        len   = LW'(l);
        run   = 1'b1;
        @(negedge clk);
        run   = 1'b0;
        start = AW'($urandom);
        incr  = AW'($urandom);
        len   = LW'($urandom);

        if (l == 0) begin
            repeat (3) begin
                checkOutput("len0 done stays high", 64'(done), 64'(1));
                checkOutput("len0 in_ready low", 64'(in_ready), 64'(0));
                @(negedge clk);
            end
            return;
        end

        checkOutput("done falls after run", 64'(done), 64'(0));

        while (sent < l && guard < 300) begin
            checkOutput("in_ready while streaming", 64'(in_ready), 64'(1));
            if (abortAfter != 0 && sent == abortAfter) begin
                in_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                checkOutput("reset mem_valid", 64'(mem_valid), 64'(0));
                checkOutput("reset in_ready", 64'(in_ready), 64'(0));
                checkOutput("reset done", 64'(done), 64'(1));
                @(negedge clk);
                rst = 1'b1;
                checkOutput("no pending writes after reset", 64'(expQ.size()), 64'(0));
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = pat[k % 7];
            endcase
            if (midRun && k == 1) begin
                start = s + AW'(5);
                len   = LW'(l + 3);
                run   = 1'b1;
            end
            in_valid = v;
            in_data  = $urandom;
            if (v) begin
                addrInt = (int'(s) + sent * int'(inc)) % DEPTH;
                e.addr  = AW'(addrInt);
                e.data  = in_data;
                e.when  = cyc + 1;
                expQ.push_back(e);
                sent++;
            end
            k++;
            guard++;
            @(negedge clk);
            run = 1'b0;
        end
        checkOutput("transfer completed in budget", 64'(sent), 64'(l));

        // Final write is on the port now; a word offered here must be refused
        in_valid = 1'b1;
        in_data  = $urandom;
        checkOutput("in_ready low after last word", 64'(in_ready), 64'(0));
        checkOutput("done low during final write", 64'(done), 64'(0));
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("done rises two cycles after last word", 64'(done), 64'(1));
        checkOutput("in_ready low when idle", 64'(in_ready), 64'(0));
        checkOutput("all writes seen", 64'(expQ.size()), 64'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int l;
        // Reset values while rst is held low
        repeat (2) @(negedge clk);
        checkOutput("reset done", 64'(done), 64'(1));
        checkOutput("reset in_ready", 64'(in_ready), 64'(0));
        checkOutput("reset mem_valid", 64'(mem_valid), 64'(0));
        checkOutput("reset mem_we", 64'(mem_we), 64'(0));
        checkOutput("reset mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset mem_wdata", 64'(mem_wdata), 64'(0));
        rst = 1'b1;

        $display("[TB] basic burst");
        applyStimulus(4'd4, 4'd1, 4, 0, 7'b0, 0, 1'b0);

        $display("[TB] stride with wrap");
        applyStimulus(4'd14, 4'd3, 3, 0, 7'b0, 0, 1'b0);

        $display("[TB] back-pressure gaps");
        applyStimulus(4'd2, 4'd2, 4, 2, 7'b1011001, 0, 1'b0);

        $display("[TB] zero length run");
        applyStimulus(4'd3, 4'd1, 0, 0, 7'b0, 0, 1'b0);

        $display("[TB] run while busy");
        applyStimulus(4'd8, 4'd1, 5, 0, 7'b0, 0, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(4'd0, 4'd1, 8, 0, 7'b0, 2, 1'b0);
        applyStimulus(4'd9, 4'd1, 3, 0, 7'b0, 0, 1'b0);

        $display("[TB] full memory load");
        for (int i = 0; i < DEPTH; i++) writeCount[i] = 0;
        applyStimulus(4'd0, 4'd1, DEPTH, 1, 7'b0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("full load writes each address once", 64'(writeCount[i]), 64'(1));
        end

        $display("[TB] random transfers");
        for (int t = 0; t < 10; t++) begin
            l = $urandom_range(1, DEPTH);
            applyStimulus(AW'($urandom), AW'($urandom), l, 1, 7'b0, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/xmem_loader.md
Name: xmem_loader

Overview:
- Upstream feeder for a Versat memory unit: drains a valid/ready word stream (DMA read data from external memory) into the memory's host write port (valid/we/addr/rdata).
- Writes go to start, start+incr, start+2*incr, ...
- Presents the standard Versat run/done control pair, so the controller treats it like any other functional unit.
- Fills the memory before the memory's own address generator is run. The loader's host-port valid overrides the address generator, so the two are never active together.

Parameters:
- MEM_ADDR_W, `MEM_ADDR_W: memory address width.
- DATA_W, 32: data word width.
- LEN_W, `MEM_ADDR_W+1: transfer length width; allows a full-memory load.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  start pulse; sampled only in IDLE.
- done  out  1  high when idle or finished.
- start  in  MEM_ADDR_W  first write address; latched on run.
- incr  in  MEM_ADDR_W  address stride; latched on run.
- len  in  LEN_W  number of words to write; latched on run.
- in_valid  in  1  stream word available.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader accepts a word this cycle.
- mem_valid  out  1  to memory valid.
- mem_we  out  1  to memory we.
- mem_addr  out  MEM_ADDR_W  to memory addr.
- mem_wdata  out  DATA_W  to memory rdata (the host write data input).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; done=1; in_ready=0; mem_valid=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - Counters and latched configuration clear to 0.
- States:
  - IDLE: done=1, in_ready=0.
  - STREAM: done=0, in_ready=1.
  - FLUSH: done=0, in_ready=0.
- IDLE -> STREAM:
  - Taken on run=1 with len!=0; config is latched that edge.
  - done falls the cycle after run.
  - run with len==0 is ignored; done stays 1.
- In STREAM, handshake = in_valid & in_ready. Each handshake:
  - Next cycle: mem_valid=1, mem_we=1, mem_addr=cur_addr, mem_wdata=in_data. All outputs are registered, so latency is 1 cycle.
  - cur_addr <= cur_addr + incr, modulo 2^MEM_ADDR_W; wrap-around is silent.
  - cnt <= cnt + 1.
- Cycles without a handshake (in_valid=0): mem_valid=0, mem_we=0; mem_addr/mem_wdata hold their last values.
- On the handshake where cnt==len-1: state -> FLUSH.
  - in_ready drops the next cycle, so no extra word is accepted.
- FLUSH: lasts exactly one cycle, the cycle in which the last write is presented; then -> IDLE.
  - done rises 2 cycles after the last handshake, after the memory has registered the write.
- run while in STREAM or FLUSH is ignored; config registers are not modified.
- Config inputs may change freely after run; only the latched copies are used.
- Throughput: 1 word/cycle sustained; in_ready has no combinational dependence on in_valid.
- Reset mid-transfer: immediate return to IDLE. Partially written words stay in memory; no further mem_valid is issued.
- mem_we equals mem_valid at all times; the loader never issues host reads.

Decomposition:
- xmemdefs.vh additions: MEM_ADDR_W, LOADER_LEN_W, and the 2-bit state encodings LDR_IDLE=0, LDR_STREAM=1, LDR_FLUSH=2.
- One natural sub-module: xloader_agen. It holds the start/incr/len latches, the strided address register and the word counter, and outputs cur_addr and last.
- The FSM and output registers stay in xmem_loader.

Test Plan:
- Basic burst: start=4, incr=1, len=4, in_valid held 1, data A,B,C,D -> writes addr 4..7 = A..D on 4 consecutive cycles; done rises 2 cycles after the 4th handshake; memory readback matches.
- Stride + wrap: MEM_ADDR_W=4, start=14, incr=3, len=3 -> addresses 14, 1, 4.
- Back-pressure gaps: in_valid pattern 1,0,0,1,1,0,1 with len=4 -> exactly 4 mem_valid pulses, each 1 cycle after its handshake; in_ready stays 1 until the last handshake.
- len=0 / run while busy:
  - run with len=0 -> done stays 1, no mem_valid.
  - Second run mid-burst with different start -> ignored; addresses follow the first config.
- Async reset mid-burst: rst=0 after 2 of 8 words, asserted between clock edges -> mem_valid, in_ready and done go to 0/0/1 immediately without waiting for a clock edge. A subsequent run starts cleanly from the new start.
- Full-memory load: len=2^MEM_ADDR_W, incr=1, start=0 -> every address written once; counter does not overflow; done asserts.
